audio_out_serializer: RTL and testbench

AUDIO_OUT_SERIALIZER -- requirements
Module: audio_out_serializer

---
 rtl/audio_out_serializer_if.sv | 31 +++
 rtl/audio_out_serializer.sv | 111 +++++++++++
 tb/tb_audio_out_serializer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_out_serializer_if.sv
// FIFO-side bundle of the audio output serializer: two show-ahead sync FIFOs
// (left/right) with empty flags, head words and one-clock pop strobes.
interface audio_out_serializer_if #(
    parameter int AUDIO_DATA_WIDTH = 16
);
    logic                        left_fifo_empty;
    logic                        right_fifo_empty;
    logic [AUDIO_DATA_WIDTH-1:0] left_fifo_data;
    logic [AUDIO_DATA_WIDTH-1:0] right_fifo_data;
    logic                        left_fifo_read_en;
    logic                        right_fifo_read_en;

    // The serializer is the consumer that initiates pops.
    modport master (
        input  left_fifo_empty,
        input  right_fifo_empty,
        input  left_fifo_data,
        input  right_fifo_data,
        output left_fifo_read_en,
        output right_fifo_read_en
    );

    modport slave (
        output left_fifo_empty,
        output right_fifo_empty,
        output left_fifo_data,
        output right_fifo_data,
        input  left_fifo_read_en,
        input  right_fifo_read_en
    );
endinterface

// File: rtl/audio_out_serializer.sv
// Left-justified I2S-style DAC serializer: pops a left/right sample pair at each
// left-frame start and shifts it out MSB first on codec BCLK falling edges.
module audio_out_serializer #(
    parameter int AUDIO_DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  bit_clk_falling_edge,
    input  logic                  left_right_clk_rising_edge,
    input  logic                  left_right_clk_falling_edge,
    audio_out_serializer_if.master fifo,
    output logic                  serial_audio_out_data,
    output logic                  underrun,
    output logic [7:0]            underrun_count
);

    localparam int CNT_W = (AUDIO_DATA_WIDTH > 1) ? $clog2(AUDIO_DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(AUDIO_DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [AUDIO_DATA_WIDTH-1:0] shift_reg;
    logic [AUDIO_DATA_WIDTH-1:0] held_right;
    logic [CNT_W-1:0]            bit_cnt;
    logic                        frame_conflict;
    logic                        left_start;
    logic                        right_start;
    logic                        have_data;
    logic                        pop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign frame_conflict = left_right_clk_rising_edge & left_right_clk_falling_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!frame_conflict) begin
            case (state)
                WAIT_SYNC: if (left_right_clk_rising_edge)  state_next = LEFT;
                LEFT:      if (left_right_clk_falling_edge) state_next = RIGHT;
                RIGHT:     if (left_right_clk_rising_edge)  state_next = LEFT;
                default:   state_next = WAIT_SYNC;
            endcase
        end
    end

    // Pops are all-or-nothing so the two channels can never slip against each other.
    always_comb begin
        left_start  = 1'b0;
        right_start = 1'b0;
        have_data   = ~fifo.left_fifo_empty & ~fifo.right_fifo_empty;
        pop         = 1'b0;
        underrun    = 1'b0;
        if (!reset && !frame_conflict) begin
            left_start  = left_right_clk_rising_edge &
                          ((state == WAIT_SYNC) || (state == RIGHT));
            right_start = left_right_clk_falling_edge & (state == LEFT);
        end
        pop      = left_start & enable & have_data;
        underrun = left_start & enable & ~have_data;
        fifo.left_fifo_read_en  = pop;
        fifo.right_fifo_read_en = pop;
    end

    // A frame load takes priority over a coincident bit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg      <= '0;
            held_right     <= '0;
            bit_cnt        <= '0;
            underrun_count <= 8'd0;
        end else begin
            if (left_start) begin
                shift_reg  <= pop ? fifo.left_fifo_data  : '0;
                held_right <= pop ? fifo.right_fifo_data : '0;
                bit_cnt    <= '0;
            end else if (right_start) begin
                shift_reg <= held_right;
                bit_cnt   <= '0;
            end else if (bit_clk_falling_edge) begin
                shift_reg <= {shift_reg[AUDIO_DATA_WIDTH-2:0], 1'b0};
                if (bit_cnt < LAST_BIT) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
            if (underrun) begin
                underrun_count <= sat_inc8(underrun_count);
            end
        end
    end

    assign serial_audio_out_data = shift_reg[AUDIO_DATA_WIDTH-1];

endmodule

// File: tb/tb_audio_out_serializer.sv
// Self-checking bench for audio_out_serializer: queue-backed FIFO model and a
// frame-level reference of the expected serial bit stream, pops and underruns.
module tb_audio_out_serializer;

    localparam int W = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       bclk = 1'b0;
    logic       lr_rise = 1'b0;
    logic       lr_fall = 1'b0;
    logic       serial_out;
    logic       underrun;
    logic [7:0] underrun_count;

    audio_out_serializer_if #(.AUDIO_DATA_WIDTH(W)) fifo ();

    audio_out_serializer #(.AUDIO_DATA_WIDTH(W)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .enable                      (enable),
        .bit_clk_falling_edge        (bclk),
        .left_right_clk_rising_edge  (lr_rise),
        .left_right_clk_falling_edge (lr_fall),
        .fifo                        (fifo),
        .serial_audio_out_data       (serial_out),
        .underrun                    (underrun),
        .underrun_count              (underrun_count)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model
    logic [W-1:0] lmem [512];
    logic [W-1:0] rmem [512];
    int lwr = 0, lrd = 0, rwr = 0, rrd = 0;
    bit flush_req = 1'b0;
    bit bad_pop = 1'b0;
    bit slip = 1'b0;

    assign fifo.left_fifo_empty  = (lrd == lwr);
    assign fifo.right_fifo_empty = (rrd == rwr);
    assign fifo.left_fifo_data   = lmem[lrd[8:0]];
    assign fifo.right_fifo_data  = rmem[rrd[8:0]];

    always @(posedge clk) begin
        if (flush_req) begin
            lrd <= lwr;
            rrd <= rwr;
        end else begin
            if (fifo.left_fifo_read_en !== fifo.right_fifo_read_en) slip <= 1'b1;
            if (fifo.left_fifo_read_en === 1'b1) begin
                if (lrd == lwr) bad_pop <= 1'b1;
                lrd <= lrd + 1;
            end
            if (fifo.right_fifo_read_en === 1'b1) begin
                if (rrd == rwr) bad_pop <= 1'b1;
                rrd <= rrd + 1;
            end
        end
    end

    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;
    logic last_lre, last_rre, last_ur, last_ser;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // One clock cycle: drive pulses, sample pop/underrun strobes mid-cycle,
    // sample the registered serial output just after the edge.
    task automatic step(input logic r, input logic f, input logic b);
        @(negedge clk);
        lr_rise = r;
        lr_fall = f;
        bclk    = b;
        #1;
        last_lre = fifo.left_fifo_read_en;
        last_rre = fifo.right_fifo_read_en;
        last_ur  = underrun;
        @(posedge clk);
        #1;
        last_ser = serial_out;
        lr_rise = 1'b0;
        lr_fall = 1'b0;
        bclk    = 1'b0;
    endtask

    task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        lmem[lwr[8:0]] = l; lwr++;
        rmem[rwr[8:0]] = r; rwr++;
    endtask

    task automatic push_left(input logic [W-1:0] l);
        lmem[lwr[8:0]] = l; lwr++;
    endtask

    task automatic push_right(input logic [W-1:0] r);
        rmem[rwr[8:0]] = r; rwr++;
    endtask

    task automatic flush_fifos();
        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
    endtask

    task automatic do_reset();
        enable = 1'b1;
        reset  = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        reset = 1'b0;
        flush_fifos();
        exp_count = 0;
    endtask

    // Frame bit i: sample MSB first, zeros once the sample is exhausted.
    function automatic logic exp_bit(input logic [W-1:0] s, input int i);
        if (i < W) return s[W-1-i];
        return 1'b0;
    endfunction

    // Plays W bit edges after a frame load (with random idle gaps) and compares every output.
    task automatic play_bits(input logic [W-1:0] s, input int gap_max, input int toggle_at,
                             input string name);
        checks++;
        if (last_ser !== exp_bit(s, 0)) begin
            errors++;
            $display("FAIL %s bit0 got=%b exp=%b", name, last_ser, exp_bit(s, 0));
        end
        for (int i = 1; i <= W; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                step(0, 0, 0);
                checks++;
                if (last_ser !== exp_bit(s, i - 1)) begin
                    errors++;
                    $display("FAIL %s idle_bit%0d got=%b exp=%b", name, i - 1, last_ser, exp_bit(s, i - 1));
                end
            end
            step(0, 0, 1);
            checks++;
            if (last_ser !== exp_bit(s, i) || last_lre !== 1'b0 || last_rre !== 1'b0) begin
                errors++;
                $display("FAIL %s bit%0d got=%b exp=%b read_en=%b%b exp=00",
                         name, i, last_ser, exp_bit(s, i), last_lre, last_rre);
            end
            if (i == toggle_at) enable = ~enable;
        end
    endtask

    // Left frame then right frame, with expectations taken from the FIFO model heads.
    task automatic run_pair(input logic coincide, input int gap_max, input int toggle_at,
                            input string name);
        logic [W-1:0] ls, rs;
        logic         exp_pop, exp_ur;
        exp_pop = enable && (lrd != lwr) && (rrd != rwr);
        exp_ur  = enable && !exp_pop;
        ls = exp_pop ? lmem[lrd[8:0]] : '0;
        rs = exp_pop ? rmem[rrd[8:0]] : '0;
        if (exp_ur && exp_count < 255) exp_count++;
        step(1, 0, coincide);
        checks++;
        if (last_lre !== exp_pop || last_rre !== exp_pop || last_ur !== exp_ur) begin
            errors++;
            $display("FAIL %s left_start read_en=%b%b underrun=%b exp read_en=%b%b underrun=%b",
                     name, last_lre, last_rre, last_ur, exp_pop, exp_pop, exp_ur);
        end
        play_bits(ls, gap_max, toggle_at, {name, "_left"});
        step(0, 1, 0);
        checks++;
        if (last_lre !== 1'b0 || last_rre !== 1'b0 || last_ur !== 1'b0) begin
            errors++;
            $display("FAIL %s right_start read_en=%b%b underrun=%b exp 00/0",
                     name, last_lre, last_rre, last_ur);
        end
        play_bits(rs, gap_max, -1, {name, "_right"});
        checks++;
        if (underrun_count !== exp_count[7:0]) begin
            errors++;
            $display("FAIL %s underrun_count got=%0d exp=%0d", name, underrun_count, exp_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        step(0, 0, 0);
        push_left(16'hFFFF);
        step(1, 0, 1);
        checks++;
        if (last_lre !== 1'b0 || last_rre !== 1'b0 || last_ur !== 1'b0 ||
            last_ser !== 1'b0 || underrun_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state read_en=%b%b underrun=%b ser=%b count=%0d exp all 0",
                     last_lre, last_rre, last_ur, last_ser, underrun_count);
        end
        reset = 1'b0;
        push_right(16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            step(0, (i < 3) ? 1'b1 : 1'b0, 1);
            checks++;
            if (last_lre !== 1'b0 || last_rre !== 1'b0 || last_ser !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle cycle%0d read_en=%b%b ser=%b exp 00/0",
                         i, last_lre, last_rre, last_ser);
            end
        end
        flush_fifos();
        exp_count = 0;
    endtask

    task automatic test_basic();
        do_reset();
        push_pair(16'hA5F0, 16'h0F0F);
        run_pair(0, 0, -1, "basic");
        checks++;
        if (lrd != lwr || rrd != rwr) begin
            errors++;
            $display("FAIL basic_pop_count left_left=%0d right_left=%0d exp 0/0", lwr - lrd, rwr - rrd);
        end
    endtask

    task automatic test_underrun();
        do_reset();
        push_left(16'h7FFF);
        run_pair(0, 1, -1, "underrun");
        checks++;
        if (underrun_count !== 8'd1 || (lwr - lrd) != 1) begin
            errors++;
            $display("FAIL underrun_single count=%0d left_depth=%0d exp 1/1", underrun_count, lwr - lrd);
        end
    endtask

    task automatic test_saturation();
        int pulses;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 302; i++) begin
            step(1, 0, 0);
            if (last_ur === 1'b1) pulses++;
            step(0, 1, 0);
        end
        checks++;
        if (pulses != 302) begin
            errors++;
            $display("FAIL saturation_pulses got=%0d exp=302", pulses);
        end
        checks++;
        if (underrun_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation_count got=%0d exp=255", underrun_count);
        end
        exp_count = 255;
    endtask

    task automatic test_fall_first();
        do_reset();
        push_pair(16'h1234, 16'h5678);
        step(0, 1, 0);
        checks++;
        if (last_lre !== 1'b0 || last_rre !== 1'b0 || last_ser !== 1'b0) begin
            errors++;
            $display("FAIL fall_first read_en=%b%b ser=%b exp 00/0", last_lre, last_rre, last_ser);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1);
            checks++;
            if (last_ser !== 1'b0) begin
                errors++;
                $display("FAIL fall_first_bits bit%0d got=%b exp=0", i, last_ser);
            end
        end
        run_pair(0, 1, -1, "fall_first");
    endtask

    task automatic test_coincident();
        do_reset();
        push_pair(16'h8001, W'($urandom));
        run_pair(1, 0, -1, "coincident");
    endtask

    task automatic test_both_edges();
        logic [W-1:0] l, r;
        do_reset();
        l = 16'hB3C5;
        r = 16'h6E29;
        push_pair(l, r);
        push_pair(16'hFFFF, 16'hFFFF);
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(1, 1, 0);
        checks++;
        if (last_lre !== 1'b0 || last_rre !== 1'b0 || last_ser !== l[W-4]) begin
            errors++;
            $display("FAIL both_edges read_en=%b%b ser=%b exp 00/%b", last_lre, last_rre, last_ser, l[W-4]);
        end
        step(0, 0, 1);
        checks++;
        if (last_ser !== l[W-5]) begin
            errors++;
            $display("FAIL both_edges_continue got=%b exp=%b", last_ser, l[W-5]);
        end
        step(0, 1, 0);
        play_bits(r, 0, -1, "both_edges_right");
    endtask

    task automatic test_enable_change();
        do_reset();
        push_pair(16'hC0DE, 16'hBEEF);
        push_pair(16'h1357, 16'h2468);
        run_pair(0, 1, 5, "en_drop");
        run_pair(0, 0, -1, "en_off");
        enable = 1'b1;
        run_pair(0, 1, -1, "en_back");
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_pair(0, 0, -1, "pre_mid_reset");
        push_pair(16'hFFFF, 16'hFFFF);
        step(1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1);
        push_pair(16'hFFFF, 16'hFFFF);
        reset = 1'b1;
        step(0, 0, 1);
        reset = 1'b0;
        checks++;
        if (last_lre !== 1'b0 || last_rre !== 1'b0 || last_ser !== 1'b0 || underrun_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid read_en=%b%b ser=%b count=%0d exp 00/0/0",
                     last_lre, last_rre, last_ser, underrun_count);
        end
        exp_count = 0;
        step(0, 1, 1);
        step(0, 0, 1);
        checks++;
        if (last_lre !== 1'b0 || last_rre !== 1'b0 || last_ser !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait read_en=%b%b ser=%b exp 00/0", last_lre, last_rre, last_ser);
        end
        run_pair(0, 0, -1, "post_mid_reset");
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(9, 0);
            if (r < 7)       push_pair(W'($urandom), W'($urandom));
            else if (r == 7) push_left(W'($urandom));
            else if (r == 8) push_right(W'($urandom));
            enable = ($urandom_range(4, 0) != 0);
            run_pair(1'($urandom_range(1, 0)), 2, -1, "random");
        end
        enable = 1'b1;
    endtask

    task automatic test_fifo_integrity();
        checks++;
        if (bad_pop !== 1'b0 || slip !== 1'b0) begin
            errors++;
            $display("FAIL fifo_integrity pop_while_empty=%b one_sided_pop=%b exp 0/0", bad_pop, slip);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_saturation();
        test_fall_first();
        test_coincident();
        test_both_edges();
        test_enable_change();
        test_reset_mid();
        test_random();
        test_fifo_integrity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
